hdc_assoc_search: RTL and testbench
===================================

Name: hdc_assoc_search

Overview:
- Parametrised, folded associative-memory search for the HDC sensor-fusion classifier.
- Compares one query hypervector against NUM_TASKS×CLASSES_PER_TASK loadable prototypes, FOLD_WIDTH bits per cycle, using Hamming distance.
- Returns the argmin class index for each task (e.g. valence, arousal).
- Sits after the spatial/temporal encoder. Prototypes are written at run time, not hard-coded.

Parameters:
- HV_DIM, 2000, hypervector width. Must be a multiple of FOLD_WIDTH.
- FOLD_WIDTH, 250, bits compared per cycle. NUM_FOLDS = HV_DIM/FOLD_WIDTH.
- NUM_TASKS, 2, independent classification outputs.
- CLASSES_PER_TASK, 2, prototypes per task. NUM_CLASSES = NUM_TASKS*CLASSES_PER_TASK.
- Derived widths:
  - IDX_W = max(1, clog2(CLASSES_PER_TASK)).
  - DIST_W = clog2(HV_DIM+1).
  - CLS_W = clog2(NUM_CLASSES).
  - FOLD_W = clog2(NUM_FOLDS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hvin_valid  in  1  query valid
- hvin_ready  out  1  block idle, can accept a query
- hvin  in  HV_DIM  query hypervector
- proto_we  in  1  prototype fold write strobe
- proto_ready  out  1  prototype writes accepted (idle only)
- proto_class  in  CLS_W  prototype index being written
- proto_fold  in  FOLD_W  fold index being written
- proto_wdata  in  FOLD_WIDTH  fold data
- dout_valid  out  1  result valid
- dout_ready  in  1  result consumed
- class_out  out  NUM_TASKS*IDX_W  per-task winning index; task t occupies bits [t*IDX_W +: IDX_W]

Behaviour:
- FSM states: IDLE, SEARCH, DONE. Reset → IDLE.
- Reset values: dout_valid=0, class_out=0, counters=0, prototype storage cleared to 0.
- IDLE:
  - hvin_ready=1 and proto_ready=1.
  - On hvin_fire, hvin is registered internally, cls=0, fold=0, next state SEARCH. The caller need not hold hvin afterwards.
- Prototype write: proto_we && proto_ready writes proto_wdata into storage[proto_class][proto_fold].
  - proto_we while proto_ready=0 is ignored.
  - Out-of-range proto_class or proto_fold is ignored.
  - A write and hvin_fire in the same cycle: the write lands first, and the search uses the updated data.
- SEARCH, one fold per cycle:
  - d = popcount(q_fold XOR proto[cls][fold]).
  - acc <= (fold==0) ? d : acc + d.
  - fold wraps at NUM_FOLDS-1, then cls increments.
- End of each class (fold==NUM_FOLDS-1):
  - total = acc + d; task t = cls / CLASSES_PER_TASK; k = cls % CLASSES_PER_TASK.
  - If k==0, or total < best[t] (strict), then best[t] <= total and idx[t] <= k.
  - Ties keep the lower index.
- After the last fold of class NUM_CLASSES-1:
  - class_out <= idx, with the final class's comparison included in the same cycle.
  - Next state DONE.
- Latency: hvin_fire at cycle 0 → dout_valid at cycle NUM_CLASSES*NUM_FOLDS+1 (33 at defaults).
- DONE:
  - dout_valid=1; class_out held stable.
  - hvin_ready=0, proto_ready=0.
  - On dout_ready → IDLE. No back-to-back overlap: hvin is accepted from the following cycle.
- Arithmetic: accumulators and best are DIST_W wide. Worst case HV_DIM, so no overflow.
- rst mid-SEARCH or in DONE: return to IDLE next cycle, dout_valid=0, partial results discarded, prototypes cleared.

Optional Feature:
- Macro: AM_DIST_OUT_EN.
- Defined:
  - Adds output port min_dist, NUM_TASKS*DIST_W wide, holding best[t] for each task.
  - Updated together with class_out, reset to 0, valid with dout_valid.
- Undefined: port absent, best[] is internal only, behaviour otherwise identical.

Test Plan:
- Load classes 0 and 2 with all zeros, classes 1 and 3 with all ones (defaults). hvin with 600 ones → dout_valid exactly 33 cycles after fire; class_out task0=0, task1=0 (600 < 1400). With AM_DIST_OUT_EN: min_dist = 600, 600.
- Same prototypes, hvin with 1500 ones → task0=1, task1=1 (500 < 1500).
- Tie: hvin with 1000 ones → task0=0, task1=0 (ties keep the lower index).
- Backpressure: hold dout_ready=0 for 10 cycles in DONE → class_out stable; hvin_ready=0 and proto_ready=0 throughout; the 11th cycle with dout_ready=1 returns to IDLE.
- Write fold 3 of class 1 during SEARCH → ignored; a following query gives the same result as before. The same write in IDLE, issued together with hvin_fire → result reflects the new data.
- Assert rst 5 cycles into SEARCH → next cycle dout_valid=0, hvin_ready=1, all prototypes read back as zero. A new query then gives class_out=0 for both tasks.

Source files
------------

// File: rtl/hdc_assoc_search.sv
// Folded Hamming-distance associative search: one query against loadable prototypes,
// per-task argmin. Define AM_DIST_OUT_EN to expose the winning distances on min_dist.
module hdc_assoc_search #(
  parameter int HV_DIM           = 2000,
  parameter int FOLD_WIDTH       = 250,
  parameter int NUM_TASKS        = 2,
  parameter int CLASSES_PER_TASK = 2,
  localparam int NUM_FOLDS   = HV_DIM / FOLD_WIDTH,
  localparam int NUM_CLASSES = NUM_TASKS * CLASSES_PER_TASK,
  localparam int IDX_W  = (CLASSES_PER_TASK > 1) ? $clog2(CLASSES_PER_TASK) : 1,
  localparam int DIST_W = $clog2(HV_DIM + 1),
  localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int FOLD_W = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hvin_valid,
  output logic                       hvin_ready,
  input  logic [HV_DIM-1:0]          hvin,
  input  logic                       proto_we,
  output logic                       proto_ready,
  input  logic [CLS_W-1:0]           proto_class,
  input  logic [FOLD_W-1:0]          proto_fold,
  input  logic [FOLD_WIDTH-1:0]      proto_wdata,
  output logic                       dout_valid,
  input  logic                       dout_ready,
`ifdef AM_DIST_OUT_EN
  output logic [NUM_TASKS*DIST_W-1:0] min_dist,
`endif
  output logic [NUM_TASKS*IDX_W-1:0] class_out
);

  // state   | meaning
  // IDLE    | accepting queries and prototype writes
  // SEARCH  | walking classes x folds, one fold per cycle
  // DONE    | result held on class_out until dout_ready
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  localparam int TASK_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

  state_t r_state, w_state_nxt;

  logic [FOLD_WIDTH-1:0]    r_proto [NUM_CLASSES][NUM_FOLDS];
  logic [FOLD_WIDTH-1:0]    r_q     [NUM_FOLDS];
  logic [CLS_W-1:0]         r_cls;
  logic [FOLD_W-1:0]        r_fold;
  logic [DIST_W-1:0]        r_acc;
  logic [DIST_W-1:0]        r_best  [NUM_TASKS];
  logic [IDX_W-1:0]         r_idx   [NUM_TASKS];
  logic [NUM_TASKS*IDX_W-1:0] r_class_out;

  logic [DIST_W-1:0]        w_d;
  logic [DIST_W-1:0]        w_sum;
  logic                     w_last_fold;
  logic                     w_last_cls;
  logic [TASK_W-1:0]        w_task;
  logic [IDX_W-1:0]         w_k;
  logic                     w_upd;
  logic [DIST_W-1:0]        w_best_nxt [NUM_TASKS];
  logic [IDX_W-1:0]         w_idx_nxt  [NUM_TASKS];
  logic [NUM_TASKS*IDX_W-1:0] w_class_pack;
  logic                     w_proto_wr;

  function automatic logic [DIST_W-1:0] popcnt(input logic [FOLD_WIDTH-1:0] v);
    logic [DIST_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < FOLD_WIDTH; i++) cnt = cnt + DIST_W'(v[i]);
    return cnt;
  endfunction

  assign w_d         = popcnt(r_q[r_fold] ^ r_proto[r_cls][r_fold]);
  assign w_sum       = (r_fold == '0) ? w_d : r_acc + w_d;
  assign w_last_fold = (r_fold == FOLD_W'(NUM_FOLDS - 1));
  assign w_last_cls  = (r_cls == CLS_W'(NUM_CLASSES - 1));
  assign w_task      = TASK_W'(int'(r_cls) / CLASSES_PER_TASK);
  assign w_k         = IDX_W'(int'(r_cls) % CLASSES_PER_TASK);
  // First class of a task seeds best; later ones win only on strictly smaller distance.
  assign w_upd       = (r_state == S_SEARCH) && w_last_fold &&
                       ((w_k == '0) || (w_sum < r_best[w_task]));
  assign w_proto_wr  = proto_we && proto_ready &&
                       (int'(proto_class) < NUM_CLASSES) && (int'(proto_fold) < NUM_FOLDS);

  always_comb begin
    w_best_nxt = r_best;
    w_idx_nxt  = r_idx;
    if (w_upd) begin
      w_best_nxt[w_task] = w_sum;
      w_idx_nxt[w_task]  = w_k;
    end
    w_class_pack = '0;
    for (int t = 0; t < NUM_TASKS; t++) w_class_pack[t*IDX_W +: IDX_W] = w_idx_nxt[t];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    hvin_ready  = 1'b0;
    proto_ready = 1'b0;
    dout_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        hvin_ready  = 1'b1;
        proto_ready = 1'b1;
        if (hvin_valid) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (w_last_fold && w_last_cls) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int f = 0; f < NUM_FOLDS; f++) r_proto[c][f] <= '0;
      for (int f = 0; f < NUM_FOLDS; f++) r_q[f] <= '0;
      for (int t = 0; t < NUM_TASKS; t++) begin
        r_best[t] <= '0;
        r_idx[t]  <= '0;
      end
      r_cls       <= '0;
      r_fold      <= '0;
      r_acc       <= '0;
      r_class_out <= '0;
    end else begin
      // Write lands this edge, so a query fired in the same cycle searches the new data.
      if (w_proto_wr) r_proto[proto_class][proto_fold] <= proto_wdata;
      case (r_state)
        S_IDLE: begin
          if (hvin_valid) begin
            for (int f = 0; f < NUM_FOLDS; f++) r_q[f] <= hvin[f*FOLD_WIDTH +: FOLD_WIDTH];
            r_cls  <= '0;
            r_fold <= '0;
            r_acc  <= '0;
          end
        end
        S_SEARCH: begin
          r_acc  <= w_sum;
          r_best <= w_best_nxt;
          r_idx  <= w_idx_nxt;
          if (w_last_fold) begin
            r_fold <= '0;
            if (w_last_cls) r_class_out <= w_class_pack;
            else            r_cls <= r_cls + CLS_W'(1);
          end else begin
            r_fold <= r_fold + FOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign class_out = r_class_out;

`ifdef AM_DIST_OUT_EN
  logic [NUM_TASKS*DIST_W-1:0] r_min_dist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_dist <= '0;
    end else if (r_state == S_SEARCH && w_last_fold && w_last_cls) begin
      for (int t = 0; t < NUM_TASKS; t++) r_min_dist[t*DIST_W +: DIST_W] <= w_best_nxt[t];
    end
  end

  assign min_dist = r_min_dist;
`endif

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Randomised self-checking bench for hdc_assoc_search against a whole-vector
// Hamming-distance argmin model.
module tb_hdc_assoc_search;
  localparam int HV_DIM = 2000;
  localparam int FW     = 250;
  localparam int NT     = 2;
  localparam int CPT    = 2;
  localparam int NF     = HV_DIM / FW;
  localparam int NC     = NT * CPT;
  localparam int IDX_W  = 1;
  localparam int DIST_W = 11;
  localparam int LAT    = NC * NF + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  hvin_valid = 1'b0;
  logic                  hvin_ready;
  logic [HV_DIM-1:0]     hvin = '0;
  logic                  proto_we = 1'b0;
  logic                  proto_ready;
  logic [1:0]            proto_class = '0;
  logic [2:0]            proto_fold = '0;
  logic [FW-1:0]         proto_wdata = '0;
  logic                  dout_valid;
  logic                  dout_ready = 1'b0;
  logic [NT*IDX_W-1:0]   class_out;
`ifdef AM_DIST_OUT_EN
  logic [NT*DIST_W-1:0]  min_dist;
`endif

  hdc_assoc_search #(.HV_DIM(HV_DIM), .FOLD_WIDTH(FW), .NUM_TASKS(NT),
                     .CLASSES_PER_TASK(CPT)) dut (
    .clk(clk), .rst(rst),
    .hvin_valid(hvin_valid), .hvin_ready(hvin_ready), .hvin(hvin),
    .proto_we(proto_we), .proto_ready(proto_ready), .proto_class(proto_class),
    .proto_fold(proto_fold), .proto_wdata(proto_wdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
`ifdef AM_DIST_OUT_EN
    .min_dist(min_dist),
`endif
    .class_out(class_out));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [HV_DIM-1:0] m_proto [NC];
  logic [NT*IDX_W-1:0]  exp_cls;
  logic [NT*DIST_W-1:0] exp_dist;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [HV_DIM-1:0] rand_hv();
    logic [HV_DIM-1:0] v;
    for (int i = 0; i < HV_DIM; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [HV_DIM-1:0] ones_hv(input int lo, input int n);
    logic [HV_DIM-1:0] v;
    v = '0;
    for (int i = lo; i < lo + n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Argmin of full-vector Hamming distance per task; first minimum wins ties.
  task automatic model(input logic [HV_DIM-1:0] q);
    int best, d;
    exp_cls = '0;
    exp_dist = '0;
    for (int t = 0; t < NT; t++) begin
      best = HV_DIM + 1;
      for (int k = 0; k < CPT; k++) begin
        d = $countones(q ^ m_proto[t*CPT + k]);
        if (d < best) begin
          best = d;
          exp_cls[t*IDX_W +: IDX_W] = IDX_W'(k);
        end
      end
      exp_dist[t*DIST_W +: DIST_W] = DIST_W'(best);
    end
  endtask

  task automatic proto_write(input int c, input int f, input logic [FW-1:0] data);
    proto_we = 1'b1;
    proto_class = 2'(c);
    proto_fold = 3'(f);
    proto_wdata = data;
    @(negedge clk);
    proto_we = 1'b0;
    m_proto[c][f*FW +: FW] = data;
  endtask

  task automatic load_proto(input int c, input logic [HV_DIM-1:0] v);
    for (int f = 0; f < NF; f++) proto_write(c, f, v[f*FW +: FW]);
  endtask

  task automatic run_query(input string tag, input logic [HV_DIM-1:0] q, input int hold,
                           input bit bad_write, input bit wr_with_fire,
                           input logic [FW-1:0] wdata);
    int n;
    logic [NT*IDX_W-1:0] held;
    chk({tag, ".hvin_ready"}, 64'(hvin_ready), 64'd1);
    hvin = q;
    hvin_valid = 1'b1;
    if (wr_with_fire) begin
      proto_we = 1'b1; proto_class = 2'd1; proto_fold = 3'd3; proto_wdata = wdata;
      m_proto[1][3*FW +: FW] = wdata;
    end
    model(q);
    @(negedge clk);
    hvin_valid = 1'b0;
    proto_we = 1'b0;
    hvin = rand_hv();
    n = 1;
    while (!dout_valid && n < LAT + 20) begin
      if (bad_write && n == 3) begin
        proto_we = 1'b1; proto_class = 2'd1; proto_fold = 3'd3; proto_wdata = wdata;
      end
      @(negedge clk);
      proto_we = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(LAT));
    chk({tag, ".class_out"}, 64'(class_out), 64'(exp_cls));
`ifdef AM_DIST_OUT_EN
    chk({tag, ".min_dist"}, 64'(min_dist), 64'(exp_dist));
`endif
    held = class_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(dout_valid), 64'd1);
      chk({tag, ".hold_class"}, 64'(class_out), 64'(held));
      chk({tag, ".hold_rdy"}, 64'({hvin_ready, proto_ready}), 64'd0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk({tag, ".release_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, ".release_rdy"}, 64'(hvin_ready), 64'd1);
  endtask

  initial begin
    logic [HV_DIM-1:0] q;
    for (int c = 0; c < NC; c++) m_proto[c] = '0;
    repeat (3) @(negedge clk);
    chk("reset.dout_valid", 64'(dout_valid), 64'd0);
    chk("reset.class_out", 64'(class_out), 64'd0);
    chk("reset.ready", 64'({hvin_ready, proto_ready}), 64'd3);
    rst = 1'b0;
    @(negedge clk);

    load_proto(0, '0);
    load_proto(1, '1);
    load_proto(2, '0);
    load_proto(3, '1);
    run_query("q600", ones_hv(0, 600), 0, 1'b0, 1'b0, '0);
    run_query("q1500", ones_hv(0, 1500), 10, 1'b0, 1'b0, '0);
    run_query("tie1000", ones_hv(0, 1000), 0, 1'b0, 1'b0, '0);

    // Upper-half query ties unless class 1 fold 3 is cleared, which tips task 0 to 1.
    q = ones_hv(1000, 1000);
    run_query("search_wr", q, 0, 1'b1, 1'b0, '0);
    run_query("after_wr", q, 0, 1'b0, 1'b0, '0);
    chk("after_wr.expect_tie", 64'(exp_cls), 64'd0);
    run_query("fire_wr", q, 0, 1'b0, 1'b1, '0);

    // Mid-search reset must discard everything including prototypes.
    load_proto(0, '1);
    load_proto(1, '0);
    q = ones_hv(0, 200);
    hvin = q;
    hvin_valid = 1'b1;
    @(negedge clk);
    hvin_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_mid.hvin_ready", 64'(hvin_ready), 64'd1);
    rst = 1'b0;
    for (int c = 0; c < NC; c++) m_proto[c] = '0;
    @(negedge clk);
    run_query("post_rst", q, 0, 1'b0, 1'b0, '0);

    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NC; c++) load_proto(c, rand_hv());
      q = m_proto[$urandom_range(0, NC - 1)];
      for (int b = 0; b < 40; b++) q[$urandom_range(0, HV_DIM - 1)] ^= 1'b1;
      if (it[0]) q = rand_hv();
      run_query("rand", q, $urandom_range(0, 3), 1'b0, 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
